// File: rtl/chunked_serial_addsub_if.sv
// Handshake and operand/result bundle for the chunked serial adder/subtractor.
// master: the side that issues operations and consumes results.
// slave:  the arithmetic block itself.
interface chunked_serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit adder slice with a registered
// carry, iterated WIDTH/CHUNK times. Subtraction is a + ~b + ~cin, so cout=1
// means "no borrow". Results are held until the consumer takes them.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// RUN   | adding one chunk per clock, LSB chunk first
// DONE  | result valid and held until out_ready
module chunked_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  chunked_serial_addsub_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("chunked_serial_addsub: WIDTH must be >= 1");
  end
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_serial_addsub: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] slice;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (cnt == LAST);

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_n = RUN;
      RUN:     if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on in_valid.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.s         = s_q;
    bus.cout      = cout_q;
    bus.ovf       = ovf_q;
  end

  // One CHUNK-bit slice of the addition; the new slice enters the sum from the top.
  always_comb begin
    {c_next, slice} = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + (CHUNK + 1)'(c_r);
    sum_next        = (sum_r >> CHUNK) | (WIDTH'(slice) << (WIDTH - CHUNK));
  end

  // Operand shift registers, carry, counter and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_r   <= bus.a;
      b_r   <= bus.sub ? ~bus.b : bus.b;
      c_r   <= bus.sub ? ~bus.cin : bus.cin;
      cnt   <= '0;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
    end else if (state == RUN) begin
      a_r   <= a_r >> CHUNK;
      b_r   <= b_r >> CHUNK;
      c_r   <= c_next;
      cnt   <= cnt + CW'(1);
      sum_r <= sum_next;
      if (last) begin
        s_q    <= sum_next;
        cout_q <= c_next;
        ovf_q  <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_addsub.sv
// Directed bench for chunked_serial_addsub: W8/C1, W8/C4 and W1/C1 instances
// sharing one clock and reset.
module tb_chunked_serial_addsub;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  chunked_serial_addsub_if #(.WIDTH(8)) if8 ();
  chunked_serial_addsub_if #(.WIDTH(8)) if4 ();
  chunked_serial_addsub_if #(.WIDTH(1)) if1 ();

  chunked_serial_addsub #(.WIDTH(8), .CHUNK(1)) u_w8c1 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  chunked_serial_addsub #(.WIDTH(8), .CHUNK(4)) u_w8c4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  chunked_serial_addsub #(.WIDTH(1), .CHUNK(1)) u_w1c1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the W8/C1 (c4=0) or W8/C4 (c4=1) instance and collect the result.
  task automatic run8(input bit c4, input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic tc, input logic ts,
                      output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    if (c4) begin
      if4.a = ta; if4.b = tb_v; if4.cin = tc; if4.sub = ts; if4.in_valid = 1'b1;
    end else begin
      if8.a = ta; if8.b = tb_v; if8.cin = tc; if8.sub = ts; if8.in_valid = 1'b1;
    end
    tick();
    if4.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!(c4 ? if4.out_valid : if8.out_valid) && lat < 40) begin
      tick();
      lat++;
    end
    if (lat >= 40) begin
      checks++;
      errors++;
      $display("FAIL run8_timeout: out_valid not seen within %0d cycles", lat);
    end
    rs = c4 ? if4.s : if8.s;
    rc = c4 ? if4.cout : if8.cout;
    ro = c4 ? if4.ovf : if8.ovf;
    if4.out_ready = 1'b1;
    if8.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
    if8.out_ready = 1'b0;
  endtask

  task automatic check_res(input string name, input logic [7:0] rs, input logic rc, input logic ro,
                           input logic [7:0] es, input logic ec, input logic eo);
    checks++;
    if ({rs, rc, ro} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL %s: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
               name, rs, rc, ro, es, ec, eo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (if8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_low: got %b expected 1", if8.in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({if8.s, if8.cout, if8.ovf, if8.out_valid, if8.in_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got s=%h cout=%b ovf=%b ov=%b ir=%b expected 00 0 0 0 1",
               if8.s, if8.cout, if8.ovf, if8.out_valid, if8.in_ready);
    end
  endtask

  task automatic test_add_c1();
    logic [7:0] rs; logic rc, ro; int lat;
    run8(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat);
    check_res("add_ff_01", rs, rc, ro, 8'h00, 1'b1, 1'b0);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL latency_c1: got %0d expected 8", lat);
    end
    run8(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat);
    check_res("add_7f_01_ovf", rs, rc, ro, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_sub_c1();
    logic [7:0] rs; logic rc, ro; int lat;
    run8(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, rs, rc, ro, lat);
    check_res("sub_05_07", rs, rc, ro, 8'hFE, 1'b0, 1'b0);
    run8(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, rs, rc, ro, lat);
    check_res("sub_80_01_ovf", rs, rc, ro, 8'h7F, 1'b1, 1'b1);
    run8(1'b0, 8'h10, 8'h03, 1'b1, 1'b1, rs, rc, ro, lat);
    check_res("sub_10_03_borrow_in", rs, rc, ro, 8'h0C, 1'b1, 1'b0);
  endtask

  task automatic test_chunk4();
    logic [7:0] rs; logic rc, ro; int lat;
    run8(1'b1, 8'h3C, 8'hC5, 1'b1, 1'b0, rs, rc, ro, lat);
    check_res("c4_add_3c_c5", rs, rc, ro, 8'h02, 1'b1, 1'b0);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL latency_c4: got %0d expected 2", lat);
    end
    run8(1'b1, 8'h60, 8'h30, 1'b0, 1'b0, rs, rc, ro, lat);
    check_res("c4_add_60_30_ovf", rs, rc, ro, 8'h90, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.sub = 1'b0; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (!if8.out_valid) begin
      errors++;
      $display("FAIL bp_no_result: out_valid not seen");
    end
    if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b1; if8.sub = 1'b1; if8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({if8.out_valid, if8.in_ready, if8.s, if8.cout, if8.ovf} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b s=%h cout=%b ovf=%b expected 1 0 46 0 0",
                 i, if8.out_valid, if8.in_ready, if8.s, if8.cout, if8.ovf);
      end
      tick();
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    tick();
    if8.out_ready = 1'b0;
    checks++;
    if ({if8.out_valid, if8.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", if8.out_valid, if8.in_ready);
    end
    tick();
    checks++;
    if (if8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored_in_valid: got ov=%b expected 0", if8.out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] rs; logic rc, ro; int lat; bit seen;
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.sub = 1'b0; if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (if8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_in_ready_in_reset: got %b expected 1", if8.in_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || if8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_discard: got seen_ov=%b ir=%b expected 0 1", seen, if8.in_ready);
    end
    run8(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, rs, rc, ro, lat);
    check_res("after_reset_10_20", rs, rc, ro, 8'h30, 1'b0, 1'b0);
  endtask

  task automatic test_w1_truth();
    logic [2:0] v;
    logic es, ec, eo;
    int lat;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      es = v[2] ^ v[1] ^ v[0];
      ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      eo = (v[2] == v[1]) && (es != v[2]);
      if1.a = v[2]; if1.b = v[1]; if1.cin = v[0]; if1.sub = 1'b0; if1.in_valid = 1'b1;
      tick();
      if1.in_valid = 1'b0;
      lat = 0;
      while (!if1.out_valid && lat < 10) begin
        tick();
        lat++;
      end
      checks++;
      if ({if1.out_valid, if1.s, if1.cout, if1.ovf} !== {1'b1, es, ec, eo} || lat !== 1) begin
        errors++;
        $display("FAIL w1_fa a=%b b=%b cin=%b: got ov=%b s=%b cout=%b ovf=%b lat=%0d expected 1 %b %b %b lat=1",
                 v[2], v[1], v[0], if1.out_valid, if1.s, if1.cout, if1.ovf, lat, es, ec, eo);
      end
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.sub = 1'b0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.sub = 1'b0; if4.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0; if1.out_ready = 1'b0;
    #2;
    test_reset();
    test_add_c1();
    test_sub_c1();
    test_chunk4();
    test_backpressure();
    test_reset_mid_run();
    test_w1_truth();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
